// File: rtl/unidade_busca.sv
// unidade_busca: fetch / memory-access stage of the multicycle MIPS datapath.
// Holds PC, IR and MDR and runs a registered request/ready handshake with
// memory; the control FSM watches Busy/Done to know when to advance.
module unidade_busca #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic        Zero,
  input  logic [1:0]  PCSource,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [31:0] ULAResult,
  input  logic [31:0] ULAOut,
  input  logic [31:0] B,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [31:0] MDR,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] Imm,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {OCIOSO, ESPERA, COMPLETA} estado_t;

  estado_t     estado;
  logic        irPend;
  logic        aceita;
  logic        pcEn;
  logic [31:0] pcNext;

  // A request is only taken when no access is outstanding.
  assign aceita = (MemRead | MemWrite) & (estado != ESPERA);

  // PC write enable and next-PC source selection (word aligned).
  assign pcEn = (PCWrite | (PCWriteCond & Zero)) & (PCSource != 2'b11);

  always_comb begin
    pcNext = PC;
    case (PCSource)
      2'b00:   pcNext = ULAResult;
      2'b01:   pcNext = ULAOut;
      2'b10:   pcNext = {PC[31:28], Instr[25:0], 2'b00};
      default: pcNext = PC;
    endcase
    pcNext[1:0] = 2'b00;
  end

  // PC register, updated independently of the access FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= RESET_PC;
    end else if (pcEn) begin
      PC <= pcNext;
    end
  end

  // Access FSM with registered strobes, IR/MDR loads and Busy/Done flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      irPend    <= 1'b0;
      Instr     <= 32'h0;
      MDR       <= 32'h0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (estado)
        ESPERA: begin
          // mem_* stay frozen until memory completes the access.
          if (mem_ready) begin
            if (mem_rd) begin
              MDR <= mem_rdata;
              if (irPend) Instr <= mem_rdata;
            end
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            irPend <= 1'b0;
            estado <= COMPLETA;
            Busy   <= 1'b0;
            Done   <= 1'b1;
          end
        end
        default: begin
          // OCIOSO and COMPLETA behave alike: accept or fall back to idle.
          if (IRWrite & ~MemRead) Instr <= MDR;
          if (aceita) begin
            mem_addr  <= IorD ? ULAOut : PC;
            mem_wdata <= B;
            mem_wr    <= MemWrite;
            mem_rd    <= MemRead & ~MemWrite;
            irPend    <= IRWrite & MemRead & ~MemWrite;
            estado    <= ESPERA;
            Busy      <= 1'b1;
          end else begin
            estado    <= OCIOSO;
            Busy      <= 1'b0;
          end
          Done <= 1'b0;
        end
      endcase
    end
  end

  // Decoded instruction fields straight from IR.
  assign Opcode = Instr[31:26];
  assign rs     = Instr[25:21];
  assign rt     = Instr[20:16];
  assign rd     = Instr[15:11];
  assign Imm    = Instr[15:0];
  assign Funct  = Instr[5:0];

endmodule
